mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_if.sv | 21 ++
 rtl/mem_responder.sv | 128 ++++++++++++
 2 files changed

// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator and mem_responder.
// Handshake: the initiator holds we_i/rd_i (with addr_i/data_i) until it sees ack_o; ack_o is a one-cycle completion pulse, err_o and data_o are meaningful only while ack_o=1.
interface mem_responder_if;
   logic [31:0] addr_i;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic        we_i;
   logic        rd_i;
   logic        ack_o;
   logic        err_o;

   modport master (
      output addr_i, data_i, we_i, rd_i,
      input  data_o, ack_o, err_o
   );

   modport slave (
      input  addr_i, data_i, we_i, rd_i,
      output data_o, ack_o, err_o
   );
endinterface

// File: rtl/mem_responder.sv
// Single-port word memory answering level requests after a fixed wait, with a boot phase and boot-done ack.
// Optional boot-time zero fill of the whole array: MEM_RESPONDER_ZERO_FILL_EN.
module mem_responder #(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   mem_responder_if.slave         bus,
   output logic [2:0]             dbg_state_o
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

`ifdef MEM_RESPONDER_ZERO_FILL_EN
   localparam int BOOT_W = ADDR_WIDTH;
`else
   localparam int BOOT_W = 4;
`endif
   localparam logic [BOOT_W-1:0] BOOT_LAST = '1;

   typedef enum logic [2:0] {
      S_BOOT     = 3'd0,
      S_BOOT_ACK = 3'd1,
      S_IDLE     = 3'd2,
      S_WAIT     = 3'd3,
      S_ACK      = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [BOOT_W-1:0]   boot_cnt_q, boot_cnt_d;
   logic [3:0]          wait_cnt_q, wait_cnt_d;
   logic [31:2]         addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                we_op_q, we_op_d;
   logic [31:0]         data_q, data_d;
   logic                err_q, err_d;

   logic [31:0]           mem_q [DEPTH];
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_idx;
   logic [31:0]           mem_wdata;
   logic [ADDR_WIDTH-1:0] word_idx;
   logic                  out_of_range;

   always_comb begin
      word_idx     = addr_q[ADDR_WIDTH+1:2];
      out_of_range = |addr_q[31:ADDR_WIDTH+2];
   end

   always_comb begin
      state_d    = state_q;
      boot_cnt_d = boot_cnt_q;
      wait_cnt_d = wait_cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      we_op_d    = we_op_q;
      data_d     = data_q;
      err_d      = err_q;
      mem_we     = 1'b0;
      mem_idx    = word_idx;
      mem_wdata  = wdata_q;
      case (state_q)
         S_BOOT: begin
`ifdef MEM_RESPONDER_ZERO_FILL_EN
            mem_we    = 1'b1;
            mem_idx   = boot_cnt_q;
            mem_wdata = '0;
`endif
            if (boot_cnt_q == BOOT_LAST) state_d = S_BOOT_ACK;
            else                         boot_cnt_d = boot_cnt_q + 1'b1;
         end
         S_BOOT_ACK: state_d = S_IDLE;
         S_IDLE: begin
            if (bus.we_i || bus.rd_i) begin
               addr_d     = bus.addr_i[31:2];
               wdata_d    = bus.data_i;
               we_op_d    = bus.we_i;
               wait_cnt_d = 4'(LATENCY - 1);
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (wait_cnt_q == 4'd0) begin
               state_d = S_ACK;
               err_d   = out_of_range;
               if (we_op_q) mem_we = !out_of_range;
               else         data_d = out_of_range ? 32'd0 : mem_q[word_idx];
            end else begin
               wait_cnt_d = wait_cnt_q - 4'd1;
            end
         end
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_BOOT;
         boot_cnt_q <= '0;
         wait_cnt_q <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_op_q    <= 1'b0;
         data_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         boot_cnt_q <= boot_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_op_q    <= we_op_d;
         data_q     <= data_d;
         err_q      <= err_d;
      end
   end

   // A reset edge wins over any pending commit, so an aborted write never lands.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) mem_q[mem_idx] <= mem_wdata;
   end

   assign bus.ack_o   = (state_q == S_ACK) || (state_q == S_BOOT_ACK);
   assign bus.err_o   = (state_q == S_ACK) && err_q;
   assign bus.data_o  = data_q;
   assign dbg_state_o = state_q;
endmodule
